// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with dead time, brightness and frame strobe.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1024,
  parameter int DEAD_CYCLES = 16,
  localparam int CNT_W      = $clog2(SCAN_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS*4-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [CNT_W-1:0]        bright,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  // state    | meaning
  // PH_BLANK | dead time at slot start, all digits off
  // PH_ON    | selected digit lit with its snapshot glyph
  // PH_OFF   | rest of slot after brightness window, all off
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_e;

  phase_e                  phase;
  logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              snap_val_q, snap_val_d;
  logic                    snap_dp_q, snap_dp_d;
  logic                    snap_blank_q, snap_blank_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    slot_start, slot_end;
  logic [3:0]              cur_val, src_val;
  logic                    cur_dp, src_dp;
  logic                    cur_blank, src_blank;
  logic [CNT_W-1:0]        lit_cnt;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_start = (slot_cnt_q == '0);
    slot_end   = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    cur_val = digits[idx_q*4 +: 4];
    cur_dp  = dp[idx_q];
`ifdef SEG7_LZ_BLANK_EN
    // Blank when this digit and everything above it is zero; digit 0 always shows.
    cur_blank = (idx_q != '0) && ((digits >> {idx_q, 2'b00}) == '0);
`else
    cur_blank = 1'b0;
`endif

    snap_val_d   = slot_start ? cur_val   : snap_val_q;
    snap_dp_d    = slot_start ? cur_dp    : snap_dp_q;
    snap_blank_d = slot_start ? cur_blank : snap_blank_q;

    // At slot start the snapshot is being loaded this edge, so use the live value.
    src_val   = snap_val_d;
    src_dp    = snap_dp_d;
    src_blank = snap_blank_d;

    lit_cnt = slot_cnt_q - CNT_W'(DEAD_CYCLES);
    if (slot_cnt_q < CNT_W'(DEAD_CYCLES)) begin
      phase = PH_BLANK;
    end else if (lit_cnt < bright) begin
      phase = PH_ON;
    end else begin
      phase = PH_OFF;
    end

    seg_d = 8'hFF;
    dig_d = '1;
    if (phase == PH_ON) begin
      seg_d = {~src_dp, src_blank ? 7'h7F : glyph(src_val)};
      dig_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    frame_d = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= 1'b0;
      snap_blank_q <= 1'b0;
      seg_q        <= 8'hFF;
      dig_q        <= '1;
      frame_q      <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_q      <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: arithmetic reference model feeds an expected queue,
// an independent monitor compares every registered output cycle.
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int CW = $clog2(SD);
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ND*4-1:0] digits = '0;
  logic [ND-1:0]   dp = '0;
  logic [CW-1:0]   bright = '0;
  logic [7:0]      seg;
  logic [ND-1:0]   dig;
  logic            frame_tick;

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .bright(bright),
    .seg(seg), .dig(dig), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [3:0] m_val = '0;
  bit m_dp = 1'b0;
  bit m_blank = 1'b0;
  logic [8+ND:0] exp_q [$];

  // Expected output after the next clock edge, from cycle position since reset release.
  task automatic push_expected();
    int p, d, on_len;
    logic [7:0] es;
    logic [ND-1:0] ed;
    logic [7:0] g;
    bit ef;
    p = n % SD;
    d = (n / SD) % ND;
    if (p == 0) begin
      m_val   = 4'((digits >> (4 * d)) & 16'hF);
      m_dp    = dp[d];
      m_blank = LZ && (d != 0) && ((digits >> (4 * d)) == 0);
    end
    on_len = (int'(bright) < SD - DC) ? int'(bright) : SD - DC;
    es = 8'hFF;
    ed = '1;
    if (p >= DC && p < DC + on_len) begin
      g  = glyph_tab[m_val];
      es = {~m_dp, m_blank ? 7'h7F : g[6:0]};
      ed[d] = 1'b0;
    end
    ef = (p == SD - 1) && (d == ND - 1);
    exp_q.push_back({es, ed, ef});
    n++;
  endtask

  task automatic run_cycles(input int cnt, input bit rnd);
    for (int i = 0; i < cnt; i++) begin
      if (rnd && $urandom_range(0, 5) == 0) begin
        digits = ND*4'($urandom);
        dp     = ND'($urandom);
        bright = CW'($urandom);
      end
      push_expected();
      @(negedge clk);
    end
  endtask

  // Asynchronous reset away from any edge; outputs must blank before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 8'hFF || dig !== '1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_blank: got seg=%h dig=%b ft=%b, want seg=ff dig=%b ft=0",
               seg, dig, frame_tick, {ND{1'b1}});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    n       = 0;
    m_val   = '0;
    m_dp    = 1'b0;
    m_blank = 1'b0;
  endtask

  always @(posedge clk) begin
    logic [8+ND:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({seg, dig, frame_tick} !== e) begin
        errors++;
        $display("FAIL scan_out t=%0t: got seg=%h dig=%b ft=%b, want seg=%h dig=%b ft=%b",
                 $time, seg, dig, frame_tick, e[8+ND -: 8], e[ND:1], e[0]);
      end
    end
  end

  initial begin
    digits = 16'h1234; dp = '0; bright = 3'd7;
    do_reset();
    run_cycles(40, 1'b0);

    bright = 3'd0;
    run_cycles(32, 1'b0);
    bright = 3'd3;
    run_cycles(32, 1'b0);

    digits = 16'h0000; dp = '0; bright = 3'd7;
    do_reset();
    run_cycles(4, 1'b0);
    digits = 16'hFFFF;
    run_cycles(40, 1'b0);

    digits = 16'h1234; dp = 4'b0100;
    run_cycles(32, 1'b0);
    dp = '0;
    digits = 16'h0050;
    run_cycles(32, 1'b0);
    digits = 16'h0000;
    run_cycles(32, 1'b0);

    run_cycles(800, 1'b1);

    digits = 16'h1234; dp = '0; bright = 3'd7;
    do_reset();
    run_cycles(20, 1'b0);
    do_reset();
    run_cycles(48, 1'b1);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
